// File: rtl/key_press_detector_pkg.sv
// key_press_detector_pkg: shared key-index encoding, FSM states and renderer geometry defaults
package key_press_detector_pkg;
    localparam int KEY_IDX_W = 4;
    localparam logic [KEY_IDX_W-1:0] KEY_NONE = 4'hF;
    localparam int DEF_NUM_KEYS = 8;
    localparam int DEF_KEYS_X = 0;
    localparam int DEF_KEYS_Y = 0;
    localparam int DEF_WHITE_KEY_WIDTH = 90;
    localparam int DEF_KEY_HEIGHT = 64;

    typedef enum logic [1:0] {ACCUM, DRAIN, EVAL, COMMIT} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return v == 16'hFFFF ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/key_press_detector_region_map.sv
// key_region_map: maps a pixel coordinate onto the white-key row (combinational)
module key_region_map import key_press_detector_pkg::*; #(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int KEYS_X = DEF_KEYS_X,
    parameter int KEYS_Y = DEF_KEYS_Y,
    parameter int WHITE_KEY_WIDTH = DEF_WHITE_KEY_WIDTH,
    parameter int KEY_HEIGHT = DEF_KEY_HEIGHT
) (
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    output logic                 in_region,
    output logic [KEY_IDX_W-1:0] key
);
    logic [11:0] h;
    logic [11:0] v;

    assign h = {1'b0, hcount};
    assign v = {2'b0, vcount};

    always_comb begin
        key = KEY_NONE;
        for (int k = 0; k < NUM_KEYS; k++)
            if (h >= 12'(KEYS_X + k * WHITE_KEY_WIDTH) && h < 12'(KEYS_X + (k + 1) * WHITE_KEY_WIDTH))
                key = KEY_IDX_W'(k);
        in_region = key != KEY_NONE && v >= 12'(KEYS_Y) && v < 12'(KEYS_Y + KEY_HEIGHT);
    end
endmodule

// File: rtl/key_press_detector.sv
// key_press_detector: per-frame key hit counting, strongest-key selection and note on/off pulses.
// Define KEY_DETECT_DEBOUNCE_EN to require DEBOUNCE_FRAMES identical frame results before committing.
module key_press_detector import key_press_detector_pkg::*; #(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int KEYS_X = DEF_KEYS_X,
    parameter int KEYS_Y = DEF_KEYS_Y,
    parameter int WHITE_KEY_WIDTH = DEF_WHITE_KEY_WIDTH,
    parameter int KEY_HEIGHT = DEF_KEY_HEIGHT,
    parameter int HIT_THRESH = 32
`ifdef KEY_DETECT_DEBOUNCE_EN
    , parameter int DEBOUNCE_FRAMES = 3
`endif
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic                 pixel_valid,
    input  logic                 hit,
    input  logic                 frame_done,
    output logic [KEY_IDX_W-1:0] key_index,
    output logic                 key_valid,
    output logic                 key_on,
    output logic                 key_off,
    output logic                 overrun
);
    localparam logic [15:0] THRESH = 16'(HIT_THRESH);

    state_t                 state;
    logic                   in_region;
    logic [KEY_IDX_W-1:0]   map_key;
    logic                   s1_valid;
    logic [KEY_IDX_W-1:0]   s1_key;
    logic [15:0]            cnt [16];
    logic                   drain;
    logic [KEY_IDX_W-1:0]   idx;
    logic [KEY_IDX_W-1:0]   best_key;
    logic [15:0]            best_cnt;
    logic [KEY_IDX_W-1:0]   cur;
    logic                   change;

    key_region_map #(
        .NUM_KEYS(NUM_KEYS), .KEYS_X(KEYS_X), .KEYS_Y(KEYS_Y),
        .WHITE_KEY_WIDTH(WHITE_KEY_WIDTH), .KEY_HEIGHT(KEY_HEIGHT)
    ) u_map (
        .hcount(hcount), .vcount(vcount), .in_region(in_region), .key(map_key)
    );

    assign cur = key_valid ? key_index : KEY_NONE;

`ifdef KEY_DETECT_DEBOUNCE_EN
    logic [KEY_IDX_W-1:0] prev_cand;
    logic [7:0]           stable;
    logic [7:0]           stable_nxt;

    assign stable_nxt = best_key == prev_cand ? (stable == 8'hFF ? stable : stable + 8'd1) : 8'd1;
    assign change = 32'(stable_nxt) >= DEBOUNCE_FRAMES && best_key != cur;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            prev_cand <= KEY_NONE;
            stable <= '0;
        end else if (state == COMMIT) begin
            prev_cand <= best_key;
            stable <= stable_nxt;
        end
`else
    assign change = best_key != cur;
`endif

    // Only ACCUM pixels enter the pipeline, so stage 2 never collides with the EVAL clear.
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_key <= '0;
            for (int k = 0; k < 16; k++) cnt[k] <= '0;
        end else begin
            s1_valid <= state == ACCUM && pixel_valid && hit && in_region;
            s1_key <= map_key;
            if (s1_valid) cnt[s1_key] <= sat_inc(cnt[s1_key]);
            if (state == EVAL) cnt[idx] <= '0;
        end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state <= ACCUM;
            drain <= 1'b0;
            idx <= '0;
            best_key <= KEY_NONE;
            best_cnt <= '0;
            key_index <= '0;
            key_valid <= 1'b0;
            key_on <= 1'b0;
            key_off <= 1'b0;
            overrun <= 1'b0;
        end else begin
            key_on <= 1'b0;
            key_off <= 1'b0;
            overrun <= frame_done && state != ACCUM;
            case (state)
                ACCUM: begin
                    drain <= 1'b0;
                    if (frame_done) state <= DRAIN;
                end
                DRAIN: begin
                    drain <= 1'b1;
                    idx <= '0;
                    best_key <= KEY_NONE;
                    best_cnt <= '0;
                    if (drain) state <= EVAL;
                end
                EVAL: begin
                    if (cnt[idx] >= THRESH && (best_key == KEY_NONE || cnt[idx] > best_cnt)) begin
                        best_key <= idx;
                        best_cnt <= cnt[idx];
                    end
                    idx <= idx + 1'b1;
                    if (idx == KEY_IDX_W'(NUM_KEYS - 1)) state <= COMMIT;
                end
                COMMIT: begin
                    state <= ACCUM;
                    if (change) begin
                        key_off <= key_valid;
                        key_valid <= best_key != KEY_NONE;
                        if (best_key != KEY_NONE) begin
                            key_index <= best_key;
                            key_on <= 1'b1;
                        end
                    end
                end
                default: state <= ACCUM;
            endcase
        end
endmodule

// File: tb/tb_key_press_detector.sv
// tb_key_press_detector: directed frames against hand-computed key/pulse expectations
module tb_key_press_detector;
    localparam int N = 8;
`ifdef KEY_DETECT_DEBOUNCE_EN
    localparam int DB = 3;
`else
    localparam int DB = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        pixel_valid = 1'b0;
    logic        hit = 1'b0;
    logic        frame_done = 1'b0;
    logic [3:0]  key_index;
    logic        key_valid;
    logic        key_on;
    logic        key_off;
    logic        overrun;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clock = ~clock;

    key_press_detector dut (
        .clock(clock), .reset_n(reset_n), .hcount(hcount), .vcount(vcount),
        .pixel_valid(pixel_valid), .hit(hit), .frame_done(frame_done),
        .key_index(key_index), .key_valid(key_valid), .key_on(key_on),
        .key_off(key_off), .overrun(overrun)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n pixels, hcount sweeping h0..h0+span-1; frame_done rides on the last one when fd is set
    task automatic pix(input int h0, input int span, input int n, input int v, input logic h, input logic fd);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            hcount = 11'(h0 + i % span);
            vcount = 10'(v);
            pixel_valid = 1'b1;
            hit = h;
            frame_done = fd && i == n - 1;
        end
    endtask

    // Watches N+5 cycles after frame_done; dbl injects a second frame_done 4 cycles later.
    task automatic fin(input string tag, input logic e_on, input logic e_off, input logic e_valid,
                       input int e_idx, input logic dbl);
        int n_on = 0, n_off = 0, n_ov = 0, on_at = 0, off_at = 0, ov_at = 0;
        for (int k = 1; k <= N + 5; k++) begin
            @(negedge clock);
            if (key_on) begin n_on++; on_at = k; end
            if (key_off) begin n_off++; off_at = k; end
            if (overrun) begin n_ov++; ov_at = k; end
            pixel_valid = 1'b0;
            hit = 1'b0;
            frame_done = dbl && k == 4;
        end
        chk({tag, " key_on count"}, n_on, int'(e_on));
        chk({tag, " key_off count"}, n_off, int'(e_off));
        chk({tag, " key_on cycle"}, on_at, e_on ? N + 4 : 0);
        chk({tag, " key_off cycle"}, off_at, e_off ? N + 4 : 0);
        chk({tag, " overrun count"}, n_ov, int'(dbl));
        chk({tag, " overrun cycle"}, ov_at, dbl ? 5 : 0);
        chk({tag, " key_valid"}, int'(key_valid), int'(e_valid));
        if (e_valid) chk({tag, " key_index"}, int'(key_index), e_idx);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("reset key_index", int'(key_index), 0);
        chk("reset key_valid", int'(key_valid), 0);
        chk("reset key_on", int'(key_on), 0);
        chk("reset key_off", int'(key_off), 0);
        chk("reset overrun", int'(overrun), 0);
        reset_n = 1'b1;

        for (int f = 1; f <= 5; f++) begin
            pix(460, 90, 20, 10, 1'b0, 1'b0);
            pix(460, 30, 31, 20, 1'b1, 1'b1);
            fin("below", 1'b0, 1'b0, 1'b0, 0, 1'b0);
        end

        for (int f = 1; f <= 3; f++) begin
            pix(200, 40, 40, 10, 1'b1, 1'b1);
            fin("single", f == DB, 1'b0, f >= DB, 2, 1'b0);
        end

        pix(400, 20, 20, 30, 1'b1, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        pixel_valid = 1'b0;
        @(negedge clock);
        chk("midreset key_index", int'(key_index), 0);
        chk("midreset key_valid", int'(key_valid), 0);
        chk("midreset key_on", int'(key_on), 0);
        chk("midreset key_off", int'(key_off), 0);
        chk("midreset overrun", int'(overrun), 0);
        reset_n = 1'b1;

        for (int f = 1; f <= 3; f++) begin
            pix(100, 50, 50, 5, 1'b1, 1'b0);
            pix(370, 50, 50, 5, 1'b1, 1'b1);
            fin("tie", f == DB, 1'b0, f >= DB, 1, 1'b0);
        end

        for (int f = 1; f <= 3; f++) begin
            pix(540, 60, 60, 63, 1'b1, 1'b1);
            fin("change", f == DB, f == DB, 1'b1, f >= DB ? 6 : 1, 1'b0);
        end

        for (int f = 1; f <= 3; f++) begin
            pix(720, 40, 40, 10, 1'b1, 1'b0);
            pix(600, 30, 40, 64, 1'b1, 1'b1);
            fin("release", 1'b0, f == DB, f < DB, 6, 1'b0);
        end

        for (int f = 1; f <= 3; f++) begin
            if (f == 1) begin
                pix(300, 1, 70000, 0, 1'b1, 1'b0);
                pix(100, 1, 4500, 0, 1'b1, 1'b1);
            end else
                pix(270, 32, 32, 0, 1'b1, 1'b1);
            fin("saturate", f == DB, 1'b0, f >= DB, 3, 1'b0);
        end

        for (int f = 1; f <= 3; f++) begin
            pix(460, 40, 40, 10, 1'b1, 1'b1);
            fin("overrun", f == DB, f == DB, 1'b1, f >= DB ? 5 : 3, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
